instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the synchronous instruction ROM. Generates the word address into the ROM and captures the returned word one cycle later.
- Presents {pc, instruction} pairs to decode over a valid/ready handshake.
- Supports branch redirect with flush of in-flight and buffered words.
- Sustains 1 instruction/cycle when decode is always ready.

Parameters:
- DATA_WIDTH, 32, instruction width; must match the ROM word width.
- ADDR_WIDTH, 16, ROM word-address width. The PC is a word address of this width.
- RESET_PC, 0, PC fetched first after reset.

Ports:
- clock  in  1  single clock for the block and the ROM.
- reset_n  in  1  synchronous, active-low reset.
- rom_address  out  ADDR_WIDTH  address to the ROM. The ROM registers it on the rising edge of clock.
- rom_q  in  DATA_WIDTH  ROM data, valid the cycle after the address is captured.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  ADDR_WIDTH  redirect target word address.
- out_valid  out  1  decode output holds a valid instruction.
- out_ready  in  1  decode accepts this cycle.
- out_instr  out  DATA_WIDTH  instruction word.
- out_pc  out  ADDR_WIDTH  word address of out_instr.

Behaviour:
- Reset (reset_n=0 at an edge):
  - pc_reg=RESET_PC, buffer count=0, inflight=0, out_valid=0.
  - out_instr=0, out_pc=0.
  - rom_address=RESET_PC while in reset.
- rom_address: combinational, = redirect_valid ? redirect_pc : pc_reg.
  - No combinational path from out_ready to rom_address.
- ROM read latency is 1: the address captured at edge N gives rom_q valid in the cycle after N, and it is sampled at edge N+1.
- State:
  - pc_reg: next address to issue.
  - inflight flag and inflight_pc: one outstanding ROM read.
  - 2-entry FIFO of {pc, instr}.
- pop = out_valid && out_ready.
- issue = reset_n && (count + inflight - pop < 2).
  - On issue: inflight<=1, inflight_pc<=rom_address, pc_reg<=rom_address+1.
  - If not issuing: inflight<=0 and pc_reg is held. The ROM re-reads the same address harmlessly.
- Return: if inflight=1 at an edge and no redirect that cycle, push {inflight_pc, rom_q} into the FIFO.
- Output: out_valid = (count != 0). out_instr/out_pc come from the FIFO head and are driven from registers.
- Held output: while out_valid=1 and out_ready=0, out_instr/out_pc are held stable. No beat is lost or duplicated.
- Redirect in cycle R:
  - A handshake in cycle R completes normally (the head is consumed).
  - All other FIFO entries and the inflight read are discarded.
  - rom_address=redirect_pc in R and is issued. pc_reg<=redirect_pc+1.
  - First valid output is out_pc=redirect_pc in cycle R+2.
- Back-to-back redirects: each redirect discards the previous one's in-flight read. Only the last target is delivered.
- PC wrap: pc increments modulo 2^ADDR_WIDTH, so (2^ADDR_WIDTH - 1) is followed by 0.
- Startup: the first cycle with reset_n=1 issues RESET_PC, and out_valid rises two cycles later.
- Throughput: with out_ready=1 continuously, one pop per cycle and consecutive PCs.
- FIFO full: count=2 suppresses issue. The occupancy rule guarantees a returning read always has space, so the FIFO never overflows.
- Reset mid-operation: returns synchronously to the reset state on the next edge. Any in-flight data is discarded.

Decomposition:
- Shared package fetch_pkg:
  - fetch_entry_t struct {pc[ADDR_WIDTH], instr[DATA_WIDTH]}.
  - FETCH_BUF_DEPTH=2.
  - ROM_READ_LATENCY=1.
- Sub-module fetch_buffer_fifo:
  - 2-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush (keeps the popped head semantics), count, head.
  - Same clock and reset_n.

Test Plan:
- Reset then out_ready=1, ROM word i = 0xA000_0000+i -> out_valid rises 2 cycles after reset release; out_pc = 0,1,2,3... each cycle; out_instr = 0xA0000000, 0xA0000001...
- out_ready=0 for 5 cycles after the 2nd beat -> out_pc=1 held stable, count saturates at 2, rom_address frozen. Releasing ready gives pc 2,3,4 with no gaps or duplicates.
- redirect_valid pulse with redirect_pc=0x0100 while streaming -> rom_address=0x0100 same cycle; out_pc sequence after the flush is 0x0100, 0x0101; no stale pc after the flush.
- Redirect in the same cycle as a handshake, plus a second redirect to 0x0200 the next cycle -> the handshake beat is consumed; only 0x0200 onward is delivered; 0x0100 never appears.
- RESET_PC=0xFFFE -> out_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- reset_n low for 1 cycle mid-stream with 2 buffered -> out_valid=0 next cycle, rom_address=RESET_PC; restart identical to the first scenario.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_WIDTH = 16;
    localparam int unsigned FETCH_DATA_WIDTH = 32;
    localparam int unsigned FETCH_BUF_DEPTH  = 2;
    localparam int unsigned ROM_READ_LATENCY = 1;

    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic [FETCH_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Buffered words plus the outstanding read, less this cycle's pop, must leave room
    // so that a read issued now always has a slot when it returns.
    function automatic logic fetch_has_room(input logic [1:0] count,
                                            input logic       inflight,
                                            input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'(FETCH_BUF_DEPTH);
    endfunction

endpackage

// File: rtl/fetch_buffer_fifo.sv
// Two-entry shift FIFO holding fetched {pc, instr} pairs; head is a register.
module fetch_buffer_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push_i,
    input  entry_t     push_entry_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output logic [1:0] count_o,
    output entry_t     head_o
);

    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // A flush drops everything, including a head that is popped in the same cycle.
        if (flush_i) begin
            count_d = '0;
        end else begin
            unique case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) head_d = push_entry_i;
                    else                 tail_d = push_entry_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = push_entry_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_entry_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the synchronous ROM address, captures the returned word and
// hands {pc, instr} to decode over valid/ready, with branch redirect and flush.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned                DATA_WIDTH = 32,
    parameter int unsigned                ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_q,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic [ADDR_WIDTH-1:0]       pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]       inflight_pc_q, inflight_pc_d;
    logic [ROM_READ_LATENCY-1:0] inflight_q, inflight_d;

    logic       pop, push, issue;
    logic [1:0] count;
    entry_t     head, push_entry;

    // rom_address depends only on reset, redirect and pc_q, never on out_ready.
    assign rom_address = !reset_n       ? RESET_PC    :
                         redirect_valid ? redirect_pc : pc_q;

    assign out_valid  = (count != 2'd0);
    assign pop        = out_valid && out_ready;
    assign issue      = reset_n && (redirect_valid || fetch_has_room(count, |inflight_q, pop));
    assign push       = (|inflight_q) && !redirect_valid;
    assign push_entry = '{pc: inflight_pc_q, instr: rom_q};

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = '0;
        if (issue) begin
            inflight_d    = '1;
            inflight_pc_d = rom_address;
            pc_d          = rom_address + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    fetch_buffer_fifo #(
        .entry_t (entry_t)
    ) u_buf (
        .clock        (clock),
        .reset_n      (reset_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .count_o      (count),
        .head_o       (head)
    );

    assign out_instr = head.instr;
    assign out_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus a wrap sequence
// on a second instance with RESET_PC = 0xFFFE.
module tb_instr_fetch_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: RESET_PC = 0
    logic        rst_a, rv_a, rdy_a, valid_a;
    logic [15:0] rpc_a, rom_addr_a, rom_addr_q_a, pc_a;
    logic [31:0] rom_q_a, instr_a;

    // Instance B: RESET_PC = 0xFFFE
    logic        rst_b, rv_b, rdy_b, valid_b;
    logic [15:0] rpc_b, rom_addr_b, rom_addr_q_b, pc_b;
    logic [31:0] rom_q_b, instr_b;

    // ROM word i = 0xA000_0000 + i, address registered on the rising edge
    always_ff @(posedge clock) begin
        rom_addr_q_a <= rom_addr_a;
        rom_addr_q_b <= rom_addr_b;
    end
    assign rom_q_a = 32'hA000_0000 + {16'h0000, rom_addr_q_a};
    assign rom_q_b = 32'hA000_0000 + {16'h0000, rom_addr_q_b};

    instr_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut_a (
        .clock(clock), .reset_n(rst_a), .rom_address(rom_addr_a), .rom_q(rom_q_a),
        .redirect_valid(rv_a), .redirect_pc(rpc_a), .out_valid(valid_a),
        .out_ready(rdy_a), .out_instr(instr_a), .out_pc(pc_a)
    );

    instr_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .RESET_PC(16'hFFFE)) dut_b (
        .clock(clock), .reset_n(rst_b), .rom_address(rom_addr_b), .rom_q(rom_q_b),
        .redirect_valid(rv_b), .redirect_pc(rpc_b), .out_valid(valid_b),
        .out_ready(rdy_b), .out_instr(instr_b), .out_pc(pc_b)
    );

    typedef struct {
        logic        rst_n;
        logic        rv;
        logic [15:0] rpc;
        logic        rdy;
        logic        exp_valid;
        logic [15:0] exp_pc;
        logic [31:0] exp_instr;
        logic [15:0] exp_rom;
        logic        chk_data;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic vec_t mk(input logic rst_n, input logic rv, input logic [15:0] rpc,
                                input logic rdy, input logic ev, input logic [15:0] epc,
                                input logic [31:0] ei, input logic [15:0] erom,
                                input logic chk);
        vec_t v;
        v.rst_n = rst_n; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_instr = ei; v.exp_rom = erom; v.chk_data = chk;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic        bv  [6];
    logic [15:0] bpc [6];
    logic [15:0] brom[6];

    initial begin
        // reset, stream, stall 5 cycles, resume
        vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 32'h0000_0000, 16'h0000, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 32'h0000_0000, 16'h0000, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 32'h0000_0000, 16'h0001, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0000, 32'hA000_0000, 16'h0002, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0001, 32'hA000_0001, 16'h0003, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0001, 32'hA000_0001, 16'h0003, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0002, 32'hA000_0002, 16'h0004, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0003, 32'hA000_0003, 16'h0005, 1));
        // redirect to 0x0100 while streaming
        vecs.push_back(mk(1, 1, 16'h0100, 1, 1, 16'h0004, 32'hA000_0004, 16'h0100, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 32'h0000_0000, 16'h0101, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0100, 32'hA000_0100, 16'h0102, 1));
        // redirect with handshake, then back-to-back redirect to 0x0200
        vecs.push_back(mk(1, 1, 16'h0100, 1, 1, 16'h0101, 32'hA000_0101, 16'h0100, 1));
        vecs.push_back(mk(1, 1, 16'h0200, 1, 0, 16'h0000, 32'h0000_0000, 16'h0200, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 32'h0000_0000, 16'h0201, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0200, 32'hA000_0200, 16'h0202, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0201, 32'hA000_0201, 16'h0203, 1));
        // fill both buffer entries, then reset mid-stream and restart
        vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0202, 32'hA000_0202, 16'h0204, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0202, 32'hA000_0202, 16'h0204, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0202, 32'hA000_0202, 16'h0000, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 32'h0000_0000, 16'h0000, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 32'h0000_0000, 16'h0001, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0000, 32'hA000_0000, 16'h0002, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0001, 32'hA000_0001, 16'h0003, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0002, 32'hA000_0002, 16'h0004, 1));

        bv[0] = 0; bpc[0] = 16'h0000; brom[0] = 16'hFFFE;
        bv[1] = 0; bpc[1] = 16'h0000; brom[1] = 16'hFFFF;
        bv[2] = 1; bpc[2] = 16'hFFFE; brom[2] = 16'h0000;
        bv[3] = 1; bpc[3] = 16'hFFFF; brom[3] = 16'h0001;
        bv[4] = 1; bpc[4] = 16'h0000; brom[4] = 16'h0002;
        bv[5] = 1; bpc[5] = 16'h0001; brom[5] = 16'h0003;

        rst_a = 1'b0; rv_a = 1'b0; rpc_a = '0; rdy_a = 1'b1;
        rst_b = 1'b0; rv_b = 1'b0; rpc_b = '0; rdy_b = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        foreach (vecs[i]) begin
            rst_a = vecs[i].rst_n;
            rv_a  = vecs[i].rv;
            rpc_a = vecs[i].rpc;
            rdy_a = vecs[i].rdy;
            @(negedge clock);
            check($sformatf("v%0d out_valid", i), {31'h0, valid_a}, {31'h0, vecs[i].exp_valid});
            check($sformatf("v%0d rom_address", i), {16'h0, rom_addr_a}, {16'h0, vecs[i].exp_rom});
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d out_pc", i), {16'h0, pc_a}, {16'h0, vecs[i].exp_pc});
                check($sformatf("v%0d out_instr", i), instr_a, vecs[i].exp_instr);
            end
            @(posedge clock);
            #1;
        end

        // PC wrap from RESET_PC = 0xFFFE; instance B has been held in reset until now
        @(negedge clock);
        check("wrap reset rom_address", {16'h0, rom_addr_b}, 32'h0000_FFFE);
        check("wrap reset out_valid", {31'h0, valid_b}, 32'h0);
        @(posedge clock);
        #1;
        rst_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check($sformatf("wrap%0d out_valid", k), {31'h0, valid_b}, {31'h0, bv[k]});
            check($sformatf("wrap%0d rom_address", k), {16'h0, rom_addr_b}, {16'h0, brom[k]});
            if (bv[k]) begin
                check($sformatf("wrap%0d out_pc", k), {16'h0, pc_b}, {16'h0, bpc[k]});
                check($sformatf("wrap%0d out_instr", k), instr_b, 32'hA000_0000 + {16'h0, bpc[k]});
            end
            @(posedge clock);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
